// File: rtl/prog_loader.sv
// Program loader: receives a length-prefixed byte stream, assembles 32-bit
// little-endian instruction words, writes them to instruction memory, verifies
// an XOR checksum and then releases the RV32I core from reset.
//
// state  | meaning
// CNT_LO | waiting for low byte of word count N
// CNT_HI | waiting for high byte of word count N
// DATA   | assembling instruction words, one byte per accepted transfer
// CSUM   | waiting for the checksum byte
// RUN    | load good, core released (terminal)
// ERR    | load failed (terminal, sticky until reset)
module prog_loader #(
  parameter int ADDR_W = 10
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_rx_valid,
  input  logic [7:0]        i_rx_data,
  output logic              o_rx_ready,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [31:0]       o_mem_wdata,
  output logic              o_core_reset,
  output logic              o_done,
  output logic              o_err
);

  // 17 bits so that DEPTH = 65536 is representable when ADDR_W = 16
  localparam logic [16:0] DEPTH = 17'(1) << ADDR_W;

  typedef enum logic [2:0] {
    S_CNT_LO,
    S_CNT_HI,
    S_DATA,
    S_CSUM,
    S_RUN,
    S_ERR
  } state_t;

  state_t              r_state;
  logic [15:0]         r_n;
  logic [15:0]         r_word_idx;
  logic [1:0]          r_byte_idx;
  logic [7:0]          r_csum;
  logic [31:0]         r_asm;
  logic                r_rx_ready;
  logic                r_mem_we;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [31:0]         r_mem_wdata;
  logic                r_core_reset;
  logic                r_done;
  logic                r_err;

  logic                w_accept;
  logic [15:0]         w_n_full;
  logic                w_last_word;
  logic [31:0]         w_word;

  assign w_accept    = i_rx_valid & r_rx_ready;
  assign w_n_full    = {i_rx_data, r_n[7:0]};
  assign w_last_word = (r_word_idx == (r_n - 16'd1));

  // Assembly register with the incoming byte merged into the current lane
  always_comb begin
    w_word = r_asm;
    case (r_byte_idx)
      2'd0: w_word[7:0]   = i_rx_data;
      2'd1: w_word[15:8]  = i_rx_data;
      2'd2: w_word[23:16] = i_rx_data;
      2'd3: w_word[31:24] = i_rx_data;
      default: w_word = r_asm;
    endcase
  end

  // Loader FSM; outputs are registered alongside the state they belong to
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state      <= S_CNT_LO;
      r_n          <= '0;
      r_word_idx   <= '0;
      r_byte_idx   <= '0;
      r_csum       <= '0;
      r_asm        <= '0;
      r_rx_ready   <= 1'b1;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_core_reset <= 1'b1;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_mem_we <= 1'b0;
      if (w_accept) begin
        case (r_state)
          S_CNT_LO: begin
            r_n[7:0] <= i_rx_data;
            r_state  <= S_CNT_HI;
          end
          S_CNT_HI: begin
            r_n[15:8]  <= i_rx_data;
            r_word_idx <= '0;
            r_byte_idx <= '0;
            if ({1'b0, w_n_full} > DEPTH) begin
              r_state    <= S_ERR;
              r_rx_ready <= 1'b0;
              r_err      <= 1'b1;
            end else if (w_n_full == 16'd0) begin
              r_state <= S_CSUM;
            end else begin
              r_state <= S_DATA;
            end
          end
          S_DATA: begin
            r_asm      <= w_word;
            r_csum     <= r_csum ^ i_rx_data;
            r_byte_idx <= r_byte_idx + 2'd1;
            if (r_byte_idx == 2'd3) begin
              r_mem_we    <= 1'b1;
              r_mem_addr  <= r_word_idx[ADDR_W-1:0];
              r_mem_wdata <= w_word;
              r_word_idx  <= r_word_idx + 16'd1;
              if (w_last_word) begin
                r_state <= S_CSUM;
              end
            end
          end
          S_CSUM: begin
            r_rx_ready <= 1'b0;
            if (i_rx_data == r_csum) begin
              r_state      <= S_RUN;
              r_core_reset <= 1'b0;
              r_done       <= 1'b1;
            end else begin
              r_state <= S_ERR;
              r_err   <= 1'b1;
            end
          end
          default: begin
            r_state <= r_state;
          end
        endcase
      end
    end
  end

  assign o_rx_ready   = r_rx_ready;
  assign o_mem_we     = r_mem_we;
  assign o_mem_addr   = r_mem_addr;
  assign o_mem_wdata  = r_mem_wdata;
  assign o_core_reset = r_core_reset;
  assign o_done       = r_done;
  assign o_err        = r_err;

endmodule
